// File: rtl/diff_acc_pkg.sv
// -----------------------------------------------------------------------------
// diff_acc_pkg
//   Shared constants, pipeline-stage structs and lane helpers for the
//   diff_accumulator block (sum of absolute differences over 16 lanes).
//   No ports; imported by sad_tree, diff_accumulator and diff_accumulator_if.
// -----------------------------------------------------------------------------
package diff_acc_pkg;

  localparam int LANES  = 16;           // lanes per input vector
  localparam int DIFF_W = 14;           // signed difference width per lane
  localparam int ABS_W  = 14;           // |lane| width; |-8192| = 8192 still fits
  localparam int S2_W   = 16;           // sum of 4 magnitudes
  localparam int TREE_W = 18;           // sum of all 16 magnitudes
  localparam int GROUPS = LANES / 4;    // first-level reduction groups
  localparam int VEC_W  = LANES * DIFF_W;

  typedef logic [VEC_W-1:0] diff_vec_t;

  // S1: per-lane magnitudes.
  typedef struct packed {
    logic                           valid;
    logic                           last;
    logic [LANES-1:0][ABS_W-1:0]    mag;
  } s1_t;

  // S2: four partial sums of four lanes each.
  typedef struct packed {
    logic                           valid;
    logic                           last;
    logic [GROUPS-1:0][S2_W-1:0]    part;
  } s2_t;

  // S3: complete per-vector sum.
  typedef struct packed {
    logic                           valid;
    logic                           last;
    logic [TREE_W-1:0]              sum;
  } s3_t;

  // Lane k occupies bits [14k+13:14k]; lane 0 is the least significant.
  function automatic logic [DIFF_W-1:0] lane_slice(input diff_vec_t vec,
                                                   input int unsigned k);
    return vec[k*DIFF_W +: DIFF_W];
  endfunction

  // Two's-complement magnitude read back as unsigned. The most negative
  // input (14'h2000) negates to itself, which as unsigned is exactly 8192.
  function automatic logic [ABS_W-1:0] abs_lane(input logic [DIFF_W-1:0] d);
    return d[DIFF_W-1] ? ABS_W'(~d + 1'b1) : ABS_W'(d);
  endfunction

endpackage

// File: rtl/diff_accumulator_if.sv
// -----------------------------------------------------------------------------
// diff_accumulator_if
//   Input (vector) and output (result) valid/ready channels of the
//   diff_accumulator block.
//   Signals:
//     in_valid / in_ready / in_diff[223:0] / in_last   -- vector channel
//     out_valid / out_ready / out_sum / out_count / out_ovf -- result channel
//   Modports:
//     master -- upstream subtractor array + downstream matcher side
//     slave  -- the diff_accumulator itself
//   ACC_W / CNT_W must match the parameters of the attached diff_accumulator.
// -----------------------------------------------------------------------------
interface diff_accumulator_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  import diff_acc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  diff_vec_t        in_diff;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_diff, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_diff, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/sad_tree.sv
// -----------------------------------------------------------------------------
// sad_tree
//   Three-stage absolute-value + reduction pipeline for one 16-lane vector.
//     S1: registered |lane| for all lanes
//     S2: four registered 16-bit sums of 4 lanes
//     S3: one registered 18-bit vector sum
//   All stages advance together when en_i is high and hold otherwise.
//   Ports:
//     clk, reset        -- clock, synchronous active-high reset
//     en_i              -- advance the pipeline this cycle
//     in_valid_i        -- in_diff_i / in_last_i carry a vector
//     in_last_i         -- vector closes its block
//     in_diff_i[223:0]  -- 16 x 14-bit signed lanes
//     out_valid_o       -- S3 holds a vector sum
//     out_last_o        -- S3 vector closes its block
//     out_sum_o[17:0]   -- S3 vector sum
// -----------------------------------------------------------------------------
module sad_tree
  import diff_acc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              in_valid_i,
  input  logic              in_last_i,
  input  diff_vec_t         in_diff_i,
  output logic              out_valid_o,
  output logic              out_last_o,
  output logic [TREE_W-1:0] out_sum_o
);

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  // NOTE: every variable written here gets a default before any branch or
  // loop touches it, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    s1_d       = '0;
    s1_d.valid = in_valid_i;
    s1_d.last  = in_last_i;
    for (int k = 0; k < LANES; k++) begin
      s1_d.mag[k] = abs_lane(lane_slice(in_diff_i, k));
    end
  end

  always_comb begin
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.last  = s1_q.last;
    for (int g = 0; g < GROUPS; g++) begin
      for (int j = 0; j < 4; j++) begin
        s2_d.part[g] = s2_d.part[g] + S2_W'(s1_q.mag[4*g+j]);
      end
    end
  end

  always_comb begin
    s3_d       = '0;
    s3_d.valid = s2_q.valid;
    s3_d.last  = s2_q.last;
    for (int g = 0; g < GROUPS; g++) begin
      s3_d.sum = s3_d.sum + TREE_W'(s2_q.part[g]);
    end
  end

  // NOTE: only the valid bits are reset; the data fields are qualified by
  // valid everywhere downstream, so clearing them would buy nothing.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q.valid <= 1'b0;
      s2_q.valid <= 1'b0;
      s3_q.valid <= 1'b0;
    end else if (en_i) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out_valid_o = s3_q.valid;
  assign out_last_o  = s3_q.last;
  assign out_sum_o   = s3_q.sum;

endmodule

// File: rtl/diff_accumulator.sv
// -----------------------------------------------------------------------------
// diff_accumulator
//   Consumer end of the 16-lane subtractor array. Takes one vector of sixteen
//   signed 14-bit differences per cycle, sums the lane magnitudes through the
//   sad_tree pipeline and accumulates the per-vector sums over a block. One
//   sum of absolute differences is emitted per block on a valid/ready channel.
//   A block ends on in_last or when it reaches 2^CNT_W vectors (force-close).
//   Latency: a last vector accepted in cycle t is presented in cycle t+4.
//   Parameters:
//     ACC_W -- accumulator / out_sum width (>= 18)
//     CNT_W -- vector counter width; longest block is 2^CNT_W vectors
//   Ports:
//     clk   -- rising-edge clock
//     reset -- synchronous active-high reset; drops partial block and pipeline
//     bus   -- diff_accumulator_if.slave (vector in, result out)
//   Build option:
//     DIFF_ACC_SATURATE_EN -- defined: accumulator clamps at all-ones;
//                             undefined: accumulator wraps modulo 2^ACC_W.
//     Either way out_ovf reports the overflow for the block.
// -----------------------------------------------------------------------------
module diff_accumulator
  import diff_acc_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  diff_accumulator_if.slave  bus
);

  // Whole pipeline freezes while a result waits on a stalled consumer; the
  // ready therefore depends only on the output register, never on in_*.
  logic stall;
  logic adv;

  logic              s3_valid;
  logic              s3_last;
  logic [TREE_W-1:0] s3_sum;

  logic [ACC_W-1:0]  acc_d, acc_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              ovf_d, ovf_q;

  logic              out_valid_d, out_valid_q;
  logic [ACC_W-1:0]  out_sum_d, out_sum_q;
  logic [CNT_W-1:0]  out_count_d, out_count_q;
  logic              out_ovf_d, out_ovf_q;

  logic [ACC_W:0]    nxt;       // one spare bit catches the carry-out
  logic              carry;
  logic [ACC_W-1:0]  acc_upd;   // accumulator value after wrap/clamp
  logic              blk_end;

  assign stall        = out_valid_q & ~bus.out_ready;
  assign adv          = ~stall;
  assign bus.in_ready = adv;

  sad_tree u_tree (
    .clk         (clk),
    .reset       (reset),
    .en_i        (adv),
    .in_valid_i  (bus.in_valid),
    .in_last_i   (bus.in_last),
    .in_diff_i   (bus.in_diff),
    .out_valid_o (s3_valid),
    .out_last_o  (s3_last),
    .out_sum_o   (s3_sum)
  );

  assign nxt   = {1'b0, acc_q} + (ACC_W+1)'(s3_sum);
  assign carry = nxt[ACC_W];

`ifdef DIFF_ACC_SATURATE_EN
  // Once clamped, any further non-zero sum carries again, so the clamp sticks.
  assign acc_upd = carry ? {ACC_W{1'b1}} : nxt[ACC_W-1:0];
`else
  assign acc_upd = nxt[ACC_W-1:0];
`endif

  // Full counter means this is vector 2^CNT_W of the block: close it now.
  assign blk_end = s3_last | (cnt_q == {CNT_W{1'b1}});

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    // Stalled: out_ready is low so this keeps out_valid. Otherwise a taken
    // result drops here and may be replaced below in the same cycle.
    out_valid_d = out_valid_q & ~bus.out_ready;

    if (adv && s3_valid) begin
      if (blk_end) begin
        out_sum_d   = acc_upd;
        out_count_d = cnt_q;
        out_valid_d = 1'b1;
        // A block closed by the counter rather than in_last is flagged too.
        out_ovf_d   = ovf_q | carry | ~s3_last;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = acc_upd;
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: doc/diff_accumulator.md
Name: diff_accumulator

Overview:
- Consumer end of the 16-lane subtractor array: accepts a vector of sixteen signed 14-bit differences (feature minus weight) per cycle.
- Forms the absolute value of each lane and reduces all lanes through a pipelined adder tree.
- Accumulates the per-vector sums across a block of vectors, producing a sum of absolute differences (SAD).
- Emits one SAD per block over a valid/ready interface to the downstream matcher.

Parameters:
ACC_W, 24, accumulator/output width in bits (must be >= 18)
CNT_W, 8, width of vector counter; max block length = 2^CNT_W vectors

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
in_valid  input  1  in_diff/in_last valid this cycle
in_ready  output  1  block can accept a vector
in_diff  input  224  16 lanes x 14-bit two's-complement; lane k = bits [14k+13:14k], lane 0 = A ... lane 15 = P
in_last  input  1  vector is the last of its block
out_valid  output  1  out_sum/out_count/out_ovf valid
out_ready  input  1  downstream accepts result
out_sum  output  ACC_W  block SAD
out_count  output  CNT_W  vectors in block minus 1
out_ovf  output  1  accumulator saturated/wrapped or block force-closed

Behaviour:
- Reset (sync, active-high): all pipeline valid bits 0, accumulator 0, counter 0, out_valid 0, out_sum 0, out_count 0, out_ovf 0. Reset mid-block discards the partial block and all in-flight vectors.
- Stall = out_valid & ~out_ready. in_ready = ~stall. While stall is high, every pipeline stage, the accumulator and the outputs hold.
- Transfer occurs when in_valid & in_ready.
- Pipeline:
  - S1 (t+1): 16 registered |lane|, 14-bit unsigned; |-8192| = 8192.
  - S2 (t+2): four 16-bit sums of 4 lanes.
  - S3 (t+3): one 18-bit vector sum.
  - ACC (t+4): accumulator update. A last vector accepted at t gives out_valid at t+4.
- Accumulate step, when the S3 result is valid and there is no stall:
  - nxt = acc + sum18, zero-extended.
  - If S3.last, or counter == 2^CNT_W-1:
    - out_sum <= nxt, out_count <= counter, out_valid <= 1, out_ovf <= ovf flag | forced-close.
    - acc, counter and ovf flag clear to 0.
  - Otherwise acc <= nxt and counter++.
- out_valid clears on out_valid & out_ready unless a new result loads in the same cycle; a new result loads in that cycle with no bubble.
- Back-to-back single-vector blocks are sustained at 1 result/cycle when out_ready stays high.
- No input combinational path to out_*. in_ready depends only on out_valid/out_ready.

Optional Feature:
- Macro: DIFF_ACC_SATURATE_EN.
- Defined: if nxt exceeds 2^ACC_W-1, acc clamps to all-ones and the ovf flag is set (sticky until block end).
- Undefined: acc wraps modulo 2^ACC_W and the ovf flag is still set on carry-out.

Decomposition:
- Package diff_acc_pkg:
  - LANES=16, DIFF_W=14, ABS_W=14, S2_W=16, TREE_W=18.
  - Lane-slice function.
  - Typedef for S1/S2 stage structs (data + valid + last).
- One sub-module, sad_tree: S1-S3 stages (abs + 3-level reduction) with enable input; diff_accumulator adds the accumulator, counter and output register.

Test Plan:
- Single-vector block: all lanes +5, in_last=1 -> out_sum=80, out_count=0, out_ovf=0, out_valid exactly 4 cycles after accept.
- Mixed signs: lanes alternate -100/+100 -> sum 1600. Lane 0 = 14'h2000 (-8192), others 0 -> out_sum=8192.
- Three-vector block: per-vector sums 16, 32, 48 with in_last on third -> out_sum=96, out_count=2; then back-to-back next block emitted on following cycle.
- Backpressure: hold out_ready=0 with result pending -> in_ready=0, out_* stable, in-flight vectors not lost. Release -> subsequent results in order, no duplicates.
- Saturation (ACC_W=18, macro on): two vectors of all lanes 8192 -> out_sum=262143, out_ovf=1. Macro off -> out_sum=0, out_ovf=1.
- Forced close (CNT_W=2): 5 vectors, no in_last -> first result out_count=3, out_ovf=1. Reset asserted mid second block -> no output, next block starts clean.
